pc_next_logic: RTL and testbench

- Next-PC selection block for the RV32I single-cycle core. It sits between the decode/branch-compare stage and the program counter.
- Combinationally computes pc_plus4 and pc_next from the current PC, rs1, and the I/B/J immediates, under a fixed JALR > JAL > branch-taken > PC+4 priority.
- Also holds a registered PC copy (pc_q) with synchronous active-low reset and stall enable, a redirect indicator, and a target-misalignment flag.

---
 rtl/pc_next_logic_pkg.sv | 19 +
 rtl/pc_next_logic.sv | 102 ++++++++++
 tb/tb_pc_next_logic.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pc_next_logic_pkg.sv
// rtl/pc_next_logic_pkg.sv - shared constants and path-select encoding for next-PC logic
//
// Purpose: common widths, increment and JALR alignment mask, plus the
//          enum naming which source feeds pc_next.
package pc_next_logic_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_INCR         = 32'd4;
  localparam logic [XLEN-1:0] JALR_ALIGN_MASK = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    SEL_PLUS4  = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JAL    = 2'd2,
    SEL_JALR   = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - RV32I next-PC selection with registered PC copy
//
// Purpose: computes pc_plus4 and pc_next (JALR > JAL > taken branch > PC+4),
//          flags redirects and misaligned targets, and keeps a stallable,
//          synchronously reset copy of the selected PC.
//
// Ports:
//   clk               in   system clock, pc_q updates on rising edge
//   rst_n             in   synchronous active-low reset (pc_q only)
//   pc_current        in   PC of the executing instruction
//   rs1_val           in   JALR base register value
//   imm_i/imm_b/imm_j in   pre-sign-extended I/B/J immediates
//   branch            in   conditional branch instruction
//   take_branch       in   branch comparator result
//   jump              in   JAL instruction
//   jalr              in   JALR instruction
//   pc_en             in   pc_q write enable (0 = stall)
//   pc_next           out  selected next PC (combinational)
//   pc_plus4          out  pc_current + 4 (combinational, link value)
//   redirect          out  non-sequential path selected (combinational)
//   target_misaligned out  pc_next not word aligned (combinational)
//   pc_q              out  registered PC
module pc_next_logic
  import pc_next_logic_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_current,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] imm_b,
  input  logic [XLEN-1:0] imm_j,
  input  logic            branch,
  input  logic            take_branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic            pc_en,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect,
  output logic            target_misaligned,
  output logic [XLEN-1:0] pc_q
);

  pc_sel_e         pc_sel;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] jal_target;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] pc_d;

  // All adds wrap modulo 2^32; carry-out is intentionally dropped.
  assign pc_plus4      = pc_current + PC_INCR;
  // Only bit0 is cleared for JALR; bit1 survives so misalignment stays visible.
  assign jalr_target   = (rs1_val + imm_i) & JALR_ALIGN_MASK;
  assign jal_target    = pc_current + imm_j;
  assign branch_target = pc_current + imm_b;

  // Priority encoder; a comparator result without a branch opcode is ignored.
  always_comb begin
    pc_sel = SEL_PLUS4;
    if (jalr) begin
      pc_sel = SEL_JALR;
    end else if (jump) begin
      pc_sel = SEL_JAL;
    end else if (branch && take_branch) begin
      pc_sel = SEL_BRANCH;
    end
  end

  always_comb begin
    pc_next = pc_plus4;
    unique case (pc_sel)
      SEL_JALR:   pc_next = jalr_target;
      SEL_JAL:    pc_next = jal_target;
      SEL_BRANCH: pc_next = branch_target;
      default:    pc_next = pc_plus4;
    endcase
  end

  // Reflects the chosen path, even if its target happens to equal PC+4.
  assign redirect          = (pc_sel != SEL_PLUS4);
  assign target_misaligned = |pc_next[1:0];

  always_comb begin
    pc_d = pc_q;
    if (pc_en) begin
      pc_d = pc_next;
    end
  end

  // Reset wins over pc_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_next_logic.sv
// tb/tb_pc_next_logic.sv - scoreboard bench for pc_next_logic
module tb_pc_next_logic;

  localparam logic [31:0] RST_VAL = 32'h0000_0080;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_current, rs1_val, imm_i, imm_b, imm_j;
  logic        branch, take_branch, jump, jalr, pc_en;
  logic [31:0] pc_next, pc_plus4, pc_q;
  logic        redirect, target_misaligned;

  pc_next_logic #(.RESET_PC(RST_VAL)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_current        (pc_current),
    .rs1_val           (rs1_val),
    .imm_i             (imm_i),
    .imm_b             (imm_b),
    .imm_j             (imm_j),
    .branch            (branch),
    .take_branch       (take_branch),
    .jump              (jump),
    .jalr              (jalr),
    .pc_en             (pc_en),
    .pc_next           (pc_next),
    .pc_plus4          (pc_plus4),
    .redirect          (redirect),
    .target_misaligned (target_misaligned),
    .pc_q              (pc_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] nxt;
    logic [31:0] p4;
    logic [31:0] pq;
    logic        redir;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_pc;
  int          checks   = 0;
  int          failures = 0;
  int          pushed   = 0;
  int          popped   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s item=%0d actual=%h required=%h", name, popped, act, exp);
    end
  endtask

  // Reference: the spec's selection rules in plain arithmetic.
  task automatic drive_vec(input logic [31:0] pc, input logic [31:0] rs1,
                           input logic [31:0] ii, input logic [31:0] ib,
                           input logic [31:0] ij, input logic br, input logic tk,
                           input logic jp, input logic jr, input logic en,
                           input logic rn);
    exp_t        e;
    logic [31:0] sum;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    pc_current = pc; rs1_val = rs1; imm_i = ii; imm_b = ib; imm_j = ij;
    branch = br; take_branch = tk; jump = jp; jalr = jr; pc_en = en; rst_n = rn;
    if (jr) begin
      sum = rs1 + ii;
      tgt = sum - (sum % 2);
    end else if (jp) begin
      tgt = pc + ij;
    end else if (br && tk) begin
      tgt = pc + ib;
    end else begin
      tgt = pc + 32'd4;
    end
    e.nxt   = tgt;
    e.p4    = pc + 32'd4;
    e.redir = jr || jp || (br && tk);
    e.mis   = (tgt % 4) != 0;
    e.pq    = model_pc;
    sb_q.push_back(e);
    pushed++;
    if (!rn)     model_pc = RST_VAL;
    else if (en) model_pc = tgt;
  endtask

  // Monitor: outputs are settled mid-cycle; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_next",  pc_next,  e.nxt);
        chk("pc_plus4", pc_plus4, e.p4);
        chk("redirect", {31'd0, redirect}, {31'd0, e.redir});
        chk("misalign", {31'd0, target_misaligned}, {31'd0, e.mis});
        chk("pc_q",     pc_q,     e.pq);
        popped++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc;
    pc_current = 32'h0; rs1_val = 32'h0; imm_i = 32'h0; imm_b = 32'h0; imm_j = 32'h0;
    branch = 0; take_branch = 0; jump = 0; jalr = 0; pc_en = 1; rst_n = 0;
    model_pc = RST_VAL;

    //        pc            rs1           imm_i   imm_b         imm_j   br tk jp jr en rn
    drive_vec(32'h100,      32'h0,        32'h0,  32'h10,       32'h20, 0, 0, 0, 0, 1, 1);
    drive_vec(32'h200,      32'h0,        32'h0,  32'h10,       32'h0,  1, 0, 0, 0, 1, 1);
    drive_vec(32'h200,      32'h0,        32'h0,  32'h10,       32'h0,  1, 1, 0, 0, 1, 1);
    drive_vec(32'h600,      32'h0,        32'h0,  32'hFFFF_FFF0,32'h0,  1, 1, 0, 0, 1, 1);
    drive_vec(32'hFFFF_FFFC,32'h0,        32'h0,  32'h0,        32'h0,  0, 0, 0, 0, 1, 1);
    drive_vec(32'h300,      32'h0,        32'h0,  32'h0,        32'h20, 0, 0, 1, 0, 1, 1);
    drive_vec(32'h0,        32'h1003,     32'h4,  32'h0,        32'h0,  0, 0, 0, 1, 1, 1);
    drive_vec(32'h400,      32'h2000,     32'h8,  32'h0,        32'h0,  0, 0, 1, 1, 1, 1);
    drive_vec(32'h500,      32'h0,        32'h0,  32'h10,       32'h40, 1, 1, 1, 0, 1, 1);
    drive_vec(32'h700,      32'h0,        32'h0,  32'h40,       32'h0,  0, 1, 0, 0, 1, 1);
    drive_vec(32'h800,      32'h0,        32'h0,  32'h0,        32'h0,  0, 0, 0, 0, 0, 1);
    drive_vec(32'h900,      32'h0,        32'h0,  32'h0,        32'h0,  0, 0, 1, 0, 0, 1);
    drive_vec(32'hA00,      32'h0,        32'h0,  32'h0,        32'h0,  0, 0, 0, 0, 0, 0);
    drive_vec(32'hB00,      32'h0,        32'h0,  32'h0,        32'h0,  0, 0, 0, 0, 1, 1);
    drive_vec(32'hC00,      32'h0,        32'h0,  32'h0,        32'h0,  0, 0, 0, 0, 1, 0);
    drive_vec(32'hD00,      32'h0,        32'h0,  32'h0,        32'h0,  0, 0, 0, 0, 1, 1);

    for (int i = 0; i < 300; i++) begin
      rpc = $urandom();
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      drive_vec(rpc, $urandom(), $urandom(), $urandom(), $urandom(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) != 0));
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("sb_count",   32'(popped),      32'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
